// File: rtl/arbitro_pkg.sv
// arbitro_pkg: shared types and helpers for the arbitro_n bus arbiter.
//   arb_state_t : arbiter ownership state (ARB_IDLE, ARB_OWNED)
//   idx_width() : max(1, $clog2(n)); sizes index and counter vectors so a
//                 degenerate parameter never yields a zero-width vector.
package arbitro_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_OWNED = 1'b1
  } arb_state_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/arbitro_pick.sv
// arbitro_pick: combinational winner selector for arbitro_n.
//   req    [N_REQ-1:0] : request vector
//   mask   [N_REQ-1:0] : requesters excluded from this pick
//   start  [IDX_W-1:0] : first index searched; the search runs upward with
//                        wrap-around (tie to 0 for plain fixed priority)
//   winner [N_REQ-1:0] : one-hot winner, zero when nothing eligible
//   idx    [IDX_W-1:0] : binary index of the winner, 0 when none
//   valid              : an eligible requester exists
module arbitro_pick
  import arbitro_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned IDX_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] mask,
  input  logic [IDX_W-1:0] start,
  output logic [N_REQ-1:0] winner,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  logic [N_REQ-1:0] cand;
  int unsigned      pos;
  logic [IDX_W-1:0] pos_w;

  always_comb begin
    cand   = req & ~mask;
    winner = '0;
    idx    = '0;
    valid  = 1'b0;
    pos    = 0;
    pos_w  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      pos = 32'(start) + i;
      if (pos >= N_REQ) pos = pos - N_REQ;
      pos_w = IDX_W'(pos);
      if (!valid && cand[pos_w]) begin
        valid         = 1'b1;
        winner[pos_w] = 1'b1;
        idx           = pos_w;
      end
    end
  end

endmodule

// File: rtl/arbitro_n.sv
// arbitro_n: registered N-way bus arbiter with grant hold and bounded tenure.
//   clk                    : rising-edge clock
//   rst_n                  : asynchronous active-low reset
//   req       [N_REQ-1:0]  : level requests, bit 0 highest fixed priority
//   grant     [N_REQ-1:0]  : registered one-hot grant, or all zero
//   grant_num [IDX_W-1:0]  : index of the granted requester, 0 when idle
//   available              : no grant currently held
// The owner keeps the grant while its req stays high; when others wait it is
// preempted after MAX_HOLD owned cycles (MAX_HOLD = 0: never preempted).
// Build option: define ARBITRO_ROUND_ROBIN_EN to start each pick just after
// the last granted index instead of always at index 0.
module arbitro_n
  import arbitro_pkg::*;
#(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned MAX_HOLD = 8,
  localparam int unsigned IDX_W   = idx_width(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_num,
  output logic             available
);

  localparam int unsigned CNT_W = idx_width(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  arb_state_t       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] grant_num_q, grant_num_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             owner_req;
  logic             others_any;
  logic             take;
  logic [IDX_W-1:0] ptr_start;
  logic [N_REQ-1:0] pick_grant;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_valid;

  assign owner_req  = |(req & grant_q);
  assign others_any = |(req & ~grant_q);

  // The current owner is always masked out: on preemption it must lose, and
  // on release its req is low anyway. In IDLE grant_q is zero, so the mask
  // is empty there without a separate path.
  arbitro_pick #(
    .N_REQ(N_REQ)
  ) u_pick (
    .req   (req),
    .mask  (grant_q),
    .start (ptr_start),
    .winner(pick_grant),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

`ifdef ARBITRO_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;

  assign ptr_start = ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (take) begin
      ptr_d = (32'(pick_idx) + 1 >= N_REQ) ? '0 : pick_idx + 1'b1;
    end
  end
`else
  assign ptr_start = '0;
`endif

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      grant_q     <= '0;
      grant_num_q <= '0;
      cnt_q       <= '0;
`ifdef ARBITRO_ROUND_ROBIN_EN
      ptr_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      grant_num_q <= grant_num_d;
      cnt_q       <= cnt_d;
`ifdef ARBITRO_ROUND_ROBIN_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  // Next-state logic; `take` marks every edge where a fresh grant is issued.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grant_num_d = grant_num_q;
    cnt_d       = cnt_q;
    take        = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (|req) take = 1'b1;
      end
      ARB_OWNED: begin
        if (owner_req) begin
          if (others_any && MAX_HOLD != 0) begin
            if (cnt_q == HOLD_LAST) take = 1'b1;
            else                    cnt_d = cnt_q + 1'b1;
          end
        end else if (others_any) begin
          take = 1'b1;
        end else begin
          state_d     = ARB_IDLE;
          grant_d     = '0;
          grant_num_d = '0;
          cnt_d       = '0;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    if (take && pick_valid) begin
      state_d     = ARB_OWNED;
      grant_d     = pick_grant;
      grant_num_d = pick_idx;
      cnt_d       = '0;
    end
  end

  // Outputs come straight from registered state.
  always_comb begin
    grant     = grant_q;
    grant_num = grant_num_q;
    available = ~|grant_q;
  end

endmodule

// File: tb/tb_arbitro_n.sv
module tb_arbitro_n;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req, req2;
  logic [0:0] req3;
  logic [3:0] grant, grant2;
  logic [1:0] grant_num, grant_num2;
  logic [0:0] grant3;
  logic [0:0] grant_num3;
  logic       available, available2, available3;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [3:0] seq2 [10];
  logic [3:0] pre_g;
  logic [1:0] pre_n;

  always #5 clk = ~clk;

  arbitro_n #(.N_REQ(4), .MAX_HOLD(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .grant(grant), .grant_num(grant_num), .available(available)
  );

  arbitro_n #(.N_REQ(4), .MAX_HOLD(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req(req2),
    .grant(grant2), .grant_num(grant_num2), .available(available2)
  );

  arbitro_n #(.N_REQ(1), .MAX_HOLD(1)) dut3 (
    .clk(clk), .rst_n(rst_n), .req(req3),
    .grant(grant3), .grant_num(grant_num3), .available(available3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] g, input logic [1:0] n, input logic a);
    n_vec++;
    assert ({grant, grant_num, available} === {g, n, a})
    else begin
      n_err++;
      $error("FAIL %s: observed grant=%b num=%0d avail=%b, expected grant=%b num=%0d avail=%b",
             tag, grant, grant_num, available, g, n, a);
    end
  endtask

  task automatic chk2(input string tag, input logic [3:0] g);
    n_vec++;
    assert ({grant2, available2} === {g, (g == 4'b0000)})
    else begin
      n_err++;
      $error("FAIL %s: observed grant=%b avail=%b, expected grant=%b avail=%b",
             tag, grant2, available2, g, (g == 4'b0000));
    end
  endtask

  task automatic chk3(input string tag);
    n_vec++;
    assert ({grant3, grant_num3, available3} === 3'b100)
    else begin
      n_err++;
      $error("FAIL %s: observed grant=%b num=%0d avail=%b, expected grant=1 num=0 avail=0",
             tag, grant3, grant_num3, available3);
    end
  endtask

  initial begin
`ifdef ARBITRO_ROUND_ROBIN_EN
    seq2 = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
             4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0001};
    pre_g = 4'b1000;
    pre_n = 2'd3;
`else
    seq2 = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0001,
             4'b0001, 4'b0010, 4'b0010, 4'b0001, 4'b0001};
    pre_g = 4'b0001;
    pre_n = 2'd0;
`endif
    rst_n = 1'b1;
    req   = 4'b0000;
    req2  = 4'b0000;
    req3  = 1'b0;

    // Reset held with all requests high: nothing may be granted.
    #3 rst_n = 1'b0;
    req = 4'b1111;
    #20;
    chk("reset", 4'b0000, 2'd0, 1'b1);
    chk2("reset2", 4'b0000);
    rst_n = 1'b1;
    tick();
    chk("first_grant", 4'b0001, 2'd0, 1'b0);

    req = 4'b0000;
    tick();
    chk("drop_to_idle", 4'b0000, 2'd0, 1'b1);

    // Owner 1 contended by 3, then 0 joins; preempt after 8 owned cycles.
    req = 4'b1010;
    tick();
    chk("fp_1010", 4'b0010, 2'd1, 1'b0);
    req = 4'b1011;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("tenure_hold", 4'b0010, 2'd1, 1'b0);
    end
    tick();
    chk("preempt", pre_g, pre_n, 1'b0);

    // Owner drops while req[2] is up: direct re-grant, then long solo hold.
    req  = 4'b0100;
    req3 = 1'b1;
    tick();
    chk("regrant", 4'b0100, 2'd2, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("alone_hold", 4'b0100, 2'd2, 1'b0);
      chk3("single_req_hold");
    end
    req = 4'b0000;
    tick();
    chk("release_idle", 4'b0000, 2'd0, 1'b1);

    // Owner 0 releases on the same edge req[3] rises: no idle cycle.
    req = 4'b0001;
    tick();
    chk("own0", 4'b0001, 2'd0, 1'b0);
    req = 4'b1000;
    tick();
    chk("handoff", 4'b1000, 2'd3, 1'b0);

    // All four requesting on the MAX_HOLD = 2 instance.
    req2 = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk2("rotation", seq2[i]);
    end

    // Asynchronous reset between edges, mid-ownership.
    #3 rst_n = 1'b0;
    #1;
    chk("async_reset", 4'b0000, 2'd0, 1'b1);
    chk2("async_reset2", 4'b0000);
    #1 rst_n = 1'b1;
    tick();
    chk("post_reset", 4'b1000, 2'd3, 1'b0);
    chk2("post_reset2_a", 4'b0001);
    tick();
    chk2("post_reset2_b", 4'b0001);
    tick();
    chk2("post_reset2_c", 4'b0010);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
